// File: rtl/rst_seq.sv
// Reset sequencer: asserts core/I2C resets asynchronously, releases core, then I2C, then Ready.
// Latency: Ready rises SYNC_STAGES+HOLD_CYCLES+STAGGER_CYCLES+2 edges after Rst_n release.
// Backpressure: none; SwRst is level-sampled and only honoured while running.
module rst_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int SW_RST_CYCLES  = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       SwRst,
    output logic       RstCore_n,
    output logic       RstI2c_n,
    output logic       Ready,
    output logic [1:0] RstCause
);

    // Catch illegal parameterisations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("rst_seq: SYNC_STAGES must be 2..4");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("rst_seq: HOLD_CYCLES must be 1..255");
    end
    if (STAGGER_CYCLES < 1 || STAGGER_CYCLES > 255) begin : g_bad_stagger
        $error("rst_seq: STAGGER_CYCLES must be 1..255");
    end
    if (SW_RST_CYCLES < 1 || SW_RST_CYCLES > 255) begin : g_bad_swrst
        $error("rst_seq: SW_RST_CYCLES must be 1..255");
    end

    // FSM encoding
    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_HOLD    = 3'd1;
    localparam logic [2:0] ST_STAGGER = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_SWRST   = 3'd4;

    // Reset cause codes
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] STAGGER_LOAD = 8'(STAGGER_CYCLES - 1);
    localparam logic [7:0] SW_LOAD      = 8'(SW_RST_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_done;

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       core_q,  core_d;
    logic       i2c_q,   i2c_d;
    logic       rdy_q,   rdy_d;
    logic [1:0] cause_q, cause_d;
    logic       cnt_zero;

    // Deassertion synchronizer: shifts in a constant 1, cleared immediately by Rst_n.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_done = sync_q[SYNC_STAGES-1];
    assign cnt_zero  = (cnt_q == 8'd0);

    // Next-state and next-output decode; outputs are registered so they never glitch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        core_d  = core_q;
        i2c_d   = i2c_q;
        rdy_d   = rdy_q;
        cause_d = cause_q;
        case (state_q)
            ST_RESET: begin
                if (sync_done) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    cause_d = CAUSE_EXT;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_STAGGER;
                    core_d  = 1'b1;
                    cnt_d   = STAGGER_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_STAGGER: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    i2c_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RUN: begin
                // A held request re-enters SWRST before Ready can rise again.
                if (SwRst) begin
                    state_d = ST_SWRST;
                    i2c_d   = 1'b0;
                    rdy_d   = 1'b0;
                    cnt_d   = SW_LOAD;
                    cause_d = CAUSE_SW;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            ST_SWRST: begin
                // Core stays out of reset; Ready follows one edge after RUN re-entry.
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    i2c_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                // Unreachable encodings fall back to a fully reset, restartable state.
                state_d = ST_RESET;
                cnt_d   = 8'd0;
                core_d  = 1'b0;
                i2c_d   = 1'b0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    // State, shared counter and output flops, all cleared asynchronously by Rst_n.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_RESET;
            cnt_q   <= 8'd0;
            core_q  <= 1'b0;
            i2c_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            core_q  <= core_d;
            i2c_q   <= i2c_d;
            rdy_q   <= rdy_d;
            cause_q <= cause_d;
        end
    end

    assign RstCore_n = core_q;
    assign RstI2c_n  = i2c_q;
    assign Ready     = rdy_q;
    assign RstCause  = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;

    typedef struct packed {
        logic       core;
        logic       i2c;
        logic       rdy;
        logic [1:0] cause;
    } exp_t;

    logic       Clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       sw_rst = 1'b0;

    logic       core0, i2c0, rdy0;
    logic [1:0] cause0;
    logic       core1, i2c1, rdy1;
    logic [1:0] cause1;

    rst_seq dut0 (
        .Clk       (Clk),
        .Rst_n     (rst_n),
        .SwRst     (sw_rst),
        .RstCore_n (core0),
        .RstI2c_n  (i2c0),
        .Ready     (rdy0),
        .RstCause  (cause0)
    );

    rst_seq #(
        .SYNC_STAGES    (4),
        .HOLD_CYCLES    (1),
        .STAGGER_CYCLES (1),
        .SW_RST_CYCLES  (1)
    ) dut1 (
        .Clk       (Clk),
        .Rst_n     (rst_n),
        .SwRst     (sw_rst),
        .RstCore_n (core1),
        .RstI2c_n  (i2c1),
        .Ready     (rdy1),
        .RstCause  (cause1)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: timestamps in release edges rather than states.
    int m_e     [2];   // release edge number (0 while in reset)
    int m_sws   [2];   // edge that started the latest software reset
    int m_swe   [2];   // edge at which that software reset ends (I2C released)
    bit m_swany [2];

    exp_t q0[$];
    exp_t q1[$];
    event ev_push;

    function automatic int p_sync(int i);  return (i == 0) ? 2  : 4; endfunction
    function automatic int p_hold(int i);  return (i == 0) ? 16 : 1; endfunction
    function automatic int p_stag(int i);  return (i == 0) ? 4  : 1; endfunction
    function automatic int p_sw(int i);    return (i == 0) ? 8  : 1; endfunction

    function automatic void m_reset(int i);
        m_e[i]     = 0;
        m_sws[i]   = -1;
        m_swe[i]   = -1;
        m_swany[i] = 1'b0;
    endfunction

    function automatic void m_step(int i, bit sw);
        int run_edge;
        m_e[i]   = m_e[i] + 1;
        run_edge = p_sync(i) + p_hold(i) + p_stag(i) + 1;
        // Running before this edge: past I2C release and past any software pulse.
        if (sw && m_e[i] > run_edge && m_e[i] > m_swe[i]) begin
            m_sws[i]   = m_e[i];
            m_swe[i]   = m_e[i] + p_sw(i);
            m_swany[i] = 1'b1;
        end
    endfunction

    function automatic exp_t m_out(int i);
        exp_t r;
        int   e;
        int   run_edge;
        e        = m_e[i];
        run_edge = p_sync(i) + p_hold(i) + p_stag(i) + 1;
        r.core   = (e >= p_sync(i) + p_hold(i) + 1);
        r.i2c    = (e >= run_edge) && !(e >= m_sws[i] && e < m_swe[i]);
        r.rdy    = (e >= run_edge + 1) && !(e >= m_sws[i] && e <= m_swe[i]);
        r.cause  = m_swany[i] ? 2'b10 : ((e >= p_sync(i) + 1) ? 2'b01 : 2'b00);
        return r;
    endfunction

    // Model: advance on every clock edge, reset instantly on Rst_n falling.
    initial begin
        m_reset(0);
        m_reset(1);
        forever begin
            @(posedge Clk or negedge rst_n);
            if (!rst_n) begin
                m_reset(0);
                m_reset(1);
            end else begin
                m_step(0, sw_rst);
                m_step(1, sw_rst);
            end
            q0.push_back(m_out(0));
            q1.push_back(m_out(1));
            -> ev_push;
        end
    end

    task automatic compare(input int i, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL dut%0d outputs t=%0t got core=%b i2c=%b rdy=%b cause=%b want core=%b i2c=%b rdy=%b cause=%b",
                     i, $time, got.core, got.i2c, got.rdy, got.cause,
                     want.core, want.i2c, want.rdy, want.cause);
        end
    endtask

    // Monitor: settle after each model update, then compare every pending expectation.
    initial begin
        exp_t w;
        forever begin
            @(ev_push);
            #1;
            while (q0.size() > 0) begin
                w = q0.pop_front();
                compare(0, {core0, i2c0, rdy0, cause0}, w);
            end
            while (q1.size() > 0) begin
                w = q1.pop_front();
                compare(1, {core1, i2c1, rdy1, cause1}, w);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Drop Rst_n between clock edges, n edges after the last negedge.
    task automatic async_drop(input int n);
        repeat (n) @(posedge Clk);
        #3 rst_n = 1'b0;
    endtask

    initial begin
        // Power-up
        rst_n  = 1'b0;
        sw_rst = 1'b0;
        cyc(5);
        rst_n = 1'b1;
        cyc(30);

        // Single-cycle software reset pulses at random points in RUN
        for (int k = 0; k < 4; k++) begin
            cyc($urandom_range(3, 15));
            sw_rst = 1'b1;
            cyc(1);
            sw_rst = 1'b0;
            cyc(12);
        end

        // Async assert mid-HOLD, then full restart
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        async_drop(10);
        cyc(2);
        rst_n = 1'b1;
        cyc(30);

        // Request held through HOLD and STAGGER, dropped before RUN
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        sw_rst = 1'b1;
        cyc(14);
        sw_rst = 1'b0;
        cyc(20);

        // Request held continuously in RUN
        sw_rst = 1'b1;
        cyc(40);
        sw_rst = 1'b0;
        cyc(20);

        // Random traffic with occasional async resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_drop(1);
                cyc($urandom_range(1, 4));
                rst_n = 1'b1;
            end else begin
                sw_rst = ($urandom_range(0, 9) == 0);
                cyc(1);
            end
        end
        sw_rst = 1'b0;
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time bound for the whole run
    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got still running want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
